// File: rtl/m_sequence_gen.sv
// Maximal-length Fibonacci LFSR bit source, advancing one bit per rising edge of gen_bit_req.
// Optional M_SEQ_REQ_SYNC_EN adds a 2-flop request synchronizer ahead of the edge detector.
module m_sequence_gen #(
  parameter int unsigned    N    = 7,
  parameter logic [N-1:0]   SEED = {N{1'b1}}
) (
  input  logic clk,
  input  logic rst_n,
  input  logic gen_bit_req,
  output logic m_seq_out,
  output logic bit_valid,
  output logic seq_start
);

  localparam int unsigned TAP_W = 16;

  // Tap mask with bit (t-1) set for every tap t of the maximal polynomial.
  function automatic logic [TAP_W-1:0] tap_mask(input int unsigned n);
    logic [TAP_W-1:0] m;
    case (n)
      3:       m = 16'h0006;
      4:       m = 16'h000C;
      5:       m = 16'h0014;
      6:       m = 16'h0030;
      7:       m = 16'h0060;
      8:       m = 16'h00B8;
      9:       m = 16'h0110;
      10:      m = 16'h0240;
      11:      m = 16'h0500;
      12:      m = 16'h0E08;
      13:      m = 16'h1C80;
      14:      m = 16'h3802;
      15:      m = 16'h6000;
      16:      m = 16'hD008;
      default: m = 16'h0000;
    endcase
    return m;
  endfunction

  localparam logic [TAP_W-1:0] TAPS_FULL = tap_mask(N);
  localparam logic [N-1:0]     TAPS      = TAPS_FULL[N-1:0];
  localparam logic [N-1:0]     ONES      = {N{1'b1}};
  localparam logic [N-1:0]     SEED_EFF  = (SEED == '0) ? ONES : SEED;

  generate
    if (N < 3 || N > 16) begin : g_bad_n
      $error("m_sequence_gen: N must be in 3..16");
    end
  endgenerate

  logic         req_in;
  logic         req_d_q, req_d_d;
  logic         req_rise;
  logic [N-1:0] state_q, state_d;
  logic         bit_valid_q, bit_valid_d;
  logic         seq_start_q, seq_start_d;
  logic         fb;

`ifdef M_SEQ_REQ_SYNC_EN
  // Two-stage synchronizer for a request source asynchronous to clk.
  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;

  always_comb begin
    sync1_d = gen_bit_req;
    sync2_d = sync1_q;
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

  assign req_in = sync2_q;
`else
  assign req_in = gen_bit_req;
`endif

  assign req_rise = req_in & ~req_d_q;
  assign fb       = ^(state_q & TAPS);

  // Next state: lockup recovery has priority over a requested shift.
  always_comb begin
    req_d_d     = req_in;
    state_d     = state_q;
    bit_valid_d = 1'b0;
    seq_start_d = 1'b0;
    if (state_q == '0) begin
      state_d = ONES;
    end else if (req_rise) begin
      state_d     = {state_q[N-2:0], fb};
      bit_valid_d = 1'b1;
      seq_start_d = (state_d == SEED_EFF);
    end
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      req_d_q     <= 1'b0;
      state_q     <= SEED_EFF;
      bit_valid_q <= 1'b0;
      seq_start_q <= 1'b0;
    end else begin
      req_d_q     <= req_d_d;
      state_q     <= state_d;
      bit_valid_q <= bit_valid_d;
      seq_start_q <= seq_start_d;
    end
  end

  assign m_seq_out = state_q[N-1];
  assign bit_valid = bit_valid_q;
  assign seq_start = seq_start_q;

endmodule

// File: tb/tb_m_sequence_gen.sv
// Randomized-spacing bench for m_sequence_gen, checked against a recurrence-based model
// of the output bit sequence (s[j] = XOR of s[j-t] over the taps).
module tb_m_sequence_gen;

  localparam int unsigned N      = 7;
  localparam int unsigned PERIOD = (1 << N) - 1;
  localparam logic [N-1:0] SEED  = '1;
`ifdef M_SEQ_REQ_SYNC_EN
  localparam int unsigned LAT = 3;
`else
  localparam int unsigned LAT = 1;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic gen_bit_req = 1'b0;
  logic m_seq_out;
  logic bit_valid;
  logic seq_start;

  int n_tests = 0;
  int n_fail  = 0;

  bit s[$];
  int k;
  int taps[2] = '{7, 6};
  bit exp_pat[8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

  m_sequence_gen #(.N(N), .SEED(SEED)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .gen_bit_req (gen_bit_req),
    .m_seq_out   (m_seq_out),
    .bit_valid   (bit_valid),
    .seq_start   (seq_start)
  );

  always #20 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (bit index %0d, t=%0t)", tag, got, exp, k, $time);
    end
  endtask

  // The first N sequence bits are the seed read MSB first.
  function automatic void model_reset();
    s.delete();
    for (int i = 0; i < int'(N); i++) s.push_back(SEED[N-1-i]);
    k = 0;
  endfunction

  function automatic bit model_bit(input int idx);
    while (s.size() <= idx) begin
      int j = s.size();
      bit b = 1'b0;
      foreach (taps[t]) b ^= s[j - taps[t]];
      s.push_back(b);
    end
    return s[idx];
  endfunction

  // One request of hi clocks high then lo clocks low; also releases reset if held.
  task automatic do_request(input int hi, input int lo);
    int   pulses = 0;
    int   lat = 0;
    int   stray = 0;
    logic ss_at = 1'b0;
    logic prev;
    @(negedge clk);
    prev = m_seq_out;
    gen_bit_req = 1'b1;
    rst_n = 1'b0;
    for (int c = 1; c <= hi + lo; c++) begin
      @(negedge clk);
      if (c == hi) gen_bit_req = 1'b0;
      if (bit_valid) begin
        pulses++;
        lat   = c;
        ss_at = seq_start;
      end else begin
        if (seq_start) stray++;
        if (m_seq_out !== prev) stray++;
      end
      prev = m_seq_out;
    end
    k++;
    check("valid_pulses", pulses, 1);
    check("latency", lat, int'(LAT));
    check("bit", int'(m_seq_out), int'(model_bit(k)));
    check("seq_start", int'(ss_at), int'(k % int'(PERIOD) == 0));
    check("stray_activity", stray, 0);
  endtask

  initial begin
    int ones = 0;

    // Reset held for 1000 ns while the request toggles.
    model_reset();
    for (int c = 0; c < 25; c++) begin
      @(negedge clk);
      gen_bit_req = c[1];
      check("rst_out", int'(m_seq_out), 1);
      check("rst_valid", int'(bit_valid), 0);
      check("rst_start", int'(seq_start), 0);
    end
    gen_bit_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("released_out", int'(m_seq_out), 1);

    // Two full periods with random request spacing.
    for (int r = 1; r <= 2 * int'(PERIOD); r++) begin
      do_request($urandom_range(6, 3), $urandom_range(6, 3));
      if (r <= 8) check("pattern", int'(m_seq_out), int'(exp_pat[r-1]));
      ones += int'(m_seq_out);
      if (k % int'(PERIOD) == 0) begin
        check("ones_per_period", ones, 64);
        ones = 0;
      end
    end

    // Request held high for 50 clocks yields a single shift.
    do_request(50, 6);

    // Advance, then reset mid-stream and confirm restart of the pattern.
    repeat (40) do_request($urandom_range(5, 3), $urandom_range(5, 3));
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("midrst_out", int'(m_seq_out), 1);
    check("midrst_valid", int'(bit_valid), 0);
    model_reset();
    for (int r = 1; r <= 8; r++) begin
      do_request($urandom_range(6, 3), $urandom_range(6, 3));
      check("restart_pattern", int'(m_seq_out), int'(exp_pat[r-1]));
    end

    // Request already high when reset releases: exactly one shift follows.
    @(negedge clk);
    rst_n = 1'b1;
    gen_bit_req = 1'b1;
    repeat (3) @(negedge clk);
    model_reset();
    do_request(4, 4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/m_sequence_gen.md
# m_sequence_gen

Maximal-length pseudo-random bit generator (Fibonacci LFSR) that supplies the test bit stream feeding the QAM symbol mapper. It advances by exactly one bit per rising edge of a slow request strobe, `gen_bit_req`, that comes from the symbol-rate logic. The block holds its output bit stable between requests.

## Interface
Parameters:
- `N` (default 7): LFSR length. Legal range is 3..16. Any other value is a compile-time error.
- `SEED` (default all ones, N bits): reset state. A value of 0 is illegal and is replaced by all ones.

Ports:
- `clk`, input, 1 bit: the single system clock. All logic is on its rising edge.
- `rst_n`, input, 1 bit: reset. Asynchronous, active-high; the block is in reset while `rst_n` = 1.
- `gen_bit_req`, input, 1 bit: request level from the symbol-rate logic. Each 0→1 transition requests one new bit.
- `m_seq_out`, output, 1 bit: current sequence bit, equal to state[N-1].
- `bit_valid`, output, 1 bit: one-cycle pulse in the cycle `m_seq_out` takes a new value.
- `seq_start`, output, 1 bit: one-cycle pulse, coincident with `bit_valid`, when the state returns to SEED (period boundary).

## Operation
- State register `state[N-1:0]`, reset to SEED.
- Feedback `fb` is the XOR of tap bits, where tap t means state[t-1]. Fixed maximal tap set per N:
  - 3:(3,2), 4:(4,3), 5:(5,3), 6:(6,5), 7:(7,6)
  - 8:(8,6,5,4), 9:(9,5), 10:(10,7), 11:(11,9)
  - 12:(12,11,10,4), 13:(13,12,11,8), 14:(14,13,12,2), 15:(15,14), 16:(16,15,13,4)
- Request edge detect: `req_d` is `gen_bit_req` registered once (reset 0); `req_rise = req_in & ~req_d`.
- On `req_rise`: state <= {state[N-2:0], fb}. With no `req_rise`, the state holds.
- Lockup guard: if the state is ever all zeros, the next clock loads all ones, regardless of request.
- Sequence period is 2^N − 1 bits. For N=7 that is 127 bits: 64 ones, 63 zeros.
- `gen_bit_req` held high or low indefinitely produces no further shifts. Only 0→1 transitions count, so each high phase yields exactly one shift.
- Reset mid-operation: the state returns to SEED and `req_d` to 0 immediately. If the request is high when reset releases, one shift occurs on the first clock after release.

## Timing
- Reset values: `m_seq_out` = SEED[N-1] (1 by default); `bit_valid` = 0; `seq_start` = 0.
- Latency, macro off: the state updates on the first rising `clk` edge that samples `gen_bit_req` = 1 after a 0 sample. `m_seq_out` and `bit_valid` are visible immediately after that edge.
- Latency, macro on: two additional clocks.
- Request spacing: minimum 2 clocks high and 2 clocks low (macro off) or 3 and 3 (macro on). Shorter pulses may be missed; no other failure is permitted.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- `M_SEQ_REQ_SYNC_EN`:
  - Defined: `gen_bit_req` passes through a 2-flop synchronizer (reset 0) before edge detection. Use this when the request source is asynchronous to `clk`. Latency becomes 3 clocks.
  - Undefined: `gen_bit_req` is treated as synchronous to `clk` and sampled directly. Latency is 1 clock.

## Test plan
- Reset: assert `rst_n` = 1 for 1000 ns with `clk` period 40 ns → `m_seq_out` = 1, `bit_valid` = 0, `seq_start` = 0 throughout.
- Default N=7, SEED=7'h7F, release reset, toggle `gen_bit_req` every 200 ns → the first 8 output bits after successive requests are 1,1,1,1,1,1,0,0. Each has a single `bit_valid` pulse, 1 clock after the sampled rise (macro off).
- Period check: run 254 requests → `seq_start` pulses after request 127 and again after request 254; 64 ones are counted per period.
- Held request: `gen_bit_req` high for 50 clocks → exactly one shift and one `bit_valid` pulse.
- Reset mid-stream: assert reset after 40 bits, then release → `m_seq_out` = 1, and the sequence restarts from the 1,1,1,1,1,1,0,0 pattern.
- `M_SEQ_REQ_SYNC_EN` defined → same bit sequence, with the state update delayed 2 extra clocks relative to the macro-off build.
